// File: rtl/act_loop_ctrl_if.sv
// act_loop_ctrl_if: start/config, fetch handshake and loop-position flags of act_loop_ctrl.
// With ACT_LOOP_CTRL_PAUSE_EN defined, the interface also carries a pause input.
interface act_loop_ctrl_if #(
  parameter int ROW_W = 5,
  parameter int BLK_W = 6,
  parameter int FRM_W = 5,
  parameter int PAT_W = 8,
  parameter int LAY_W = 6
);
  logic             start;
  logic [ROW_W-1:0] cfg_len_row;
  logic [ROW_W-1:0] cfg_num_row;
  logic [BLK_W-1:0] cfg_num_blk;
  logic [FRM_W-1:0] cfg_num_frm;
  logic [PAT_W-1:0] cfg_num_pat;
  logic [LAY_W-1:0] cfg_num_lay;
  logic             fetch_req;
  logic             fetch_ack;
  logic             frt_act_row;
  logic             lst_act_row;
  logic             lst_act_blk;
  logic             frt_blk;
  logic             val_psum;
  logic             fnh_frm;
  logic             busy;
  logic             done;
`ifdef ACT_LOOP_CTRL_PAUSE_EN
  logic             pause;
`endif

  // Controller side
  modport slave (
`ifdef ACT_LOOP_CTRL_PAUSE_EN
    input  pause,
`endif
    input  start, cfg_len_row, cfg_num_row, cfg_num_blk, cfg_num_frm, cfg_num_pat,
           cfg_num_lay, fetch_ack,
    output fetch_req, frt_act_row, lst_act_row, lst_act_blk, frt_blk, val_psum,
           fnh_frm, busy, done
  );

  // Sequencer / memory side
  modport master (
`ifdef ACT_LOOP_CTRL_PAUSE_EN
    output pause,
`endif
    output start, cfg_len_row, cfg_num_row, cfg_num_blk, cfg_num_frm, cfg_num_pat,
           cfg_num_lay, fetch_ack,
    input  fetch_req, frt_act_row, lst_act_row, lst_act_blk, frt_blk, val_psum,
           fnh_frm, busy, done
  );
endinterface

// File: rtl/act_loop_ctrl.sv
// act_loop_ctrl: walks act -> row -> block -> frame -> patch -> layer loops, one
// fetch request per activation word, and emits loop-position flags for the PEC.
// Optional feature: define ACT_LOOP_CTRL_PAUSE_EN to add a pause input that stalls
// fetching without losing position.
module act_loop_ctrl #(
  parameter int ROW_W     = 5,
  parameter int BLK_W     = 6,
  parameter int FRM_W     = 5,
  parameter int PAT_W     = 8,
  parameter int LAY_W     = 6,
  parameter int DROP_ROWS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  act_loop_ctrl_if.slave io_bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [ROW_W-1:0] DROP_V = ROW_W'(DROP_ROWS);

  state_t           r_state, w_state_nxt;
  logic [ROW_W-1:0] r_len_row, r_num_row, r_act, r_row;
  logic [BLK_W-1:0] r_num_blk, r_blk;
  logic [FRM_W-1:0] r_num_frm, r_frm;
  logic [PAT_W-1:0] r_num_pat, r_pat;
  logic [LAY_W-1:0] r_num_lay, r_lay;
  logic             r_fnh_frm;
  logic             w_run, w_fetch_req, w_beat, w_busy, w_done;
  logic             w_wrap_act, w_wrap_row, w_wrap_blk, w_wrap_frm, w_wrap_pat, w_wrap_lay;

  assign w_run = (r_state == S_RUN);
`ifdef ACT_LOOP_CTRL_PAUSE_EN
  assign w_fetch_req = w_run && !io_bus.pause;
`else
  assign w_fetch_req = w_run;
`endif
  assign w_beat = w_fetch_req && io_bus.fetch_ack;

  // Each level wraps only when every inner level wraps on the same beat.
  assign w_wrap_act = (r_act == r_len_row);
  assign w_wrap_row = w_wrap_act && (r_row == r_num_row);
  assign w_wrap_blk = w_wrap_row && (r_blk == r_num_blk);
  assign w_wrap_frm = w_wrap_blk && (r_frm == r_num_frm);
  assign w_wrap_pat = w_wrap_frm && (r_pat == r_num_pat);
  assign w_wrap_lay = w_wrap_pat && (r_lay == r_num_lay);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and status outputs; the final beat is the one where every level wraps
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (io_bus.start) w_state_nxt = S_RUN;
      S_RUN: begin
        w_busy = 1'b1;
        if (w_beat && w_wrap_lay) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Config capture on start; loop counters advance only on a beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_row <= '0; r_num_row <= '0; r_num_blk <= '0;
      r_num_frm <= '0; r_num_pat <= '0; r_num_lay <= '0;
      r_act <= '0; r_row <= '0; r_blk <= '0;
      r_frm <= '0; r_pat <= '0; r_lay <= '0;
    end else if (r_state == S_IDLE && io_bus.start) begin
      r_len_row <= io_bus.cfg_len_row;
      r_num_row <= io_bus.cfg_num_row;
      r_num_blk <= io_bus.cfg_num_blk;
      r_num_frm <= io_bus.cfg_num_frm;
      r_num_pat <= io_bus.cfg_num_pat;
      r_num_lay <= io_bus.cfg_num_lay;
      r_act <= '0; r_row <= '0; r_blk <= '0;
      r_frm <= '0; r_pat <= '0; r_lay <= '0;
    end else if (w_beat) begin
      r_act <= w_wrap_act ? '0 : r_act + 1'b1;
      if (w_wrap_act) r_row <= w_wrap_row ? '0 : r_row + 1'b1;
      if (w_wrap_row) r_blk <= w_wrap_blk ? '0 : r_blk + 1'b1;
      if (w_wrap_blk) r_frm <= w_wrap_frm ? '0 : r_frm + 1'b1;
      if (w_wrap_frm) r_pat <= w_wrap_pat ? '0 : r_pat + 1'b1;
      if (w_wrap_pat) r_lay <= w_wrap_lay ? '0 : r_lay + 1'b1;
    end
  end

  // Frame-done strobe, one cycle after the beat that wraps the block counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fnh_frm <= 1'b0;
    else        r_fnh_frm <= w_beat && w_wrap_blk;
  end

  assign io_bus.fetch_req   = w_fetch_req;
  assign io_bus.frt_act_row = (r_act == '0);
  assign io_bus.lst_act_row = w_run && w_wrap_act;
  assign io_bus.lst_act_blk = w_run && w_wrap_row;
  assign io_bus.frt_blk     = (r_blk == '0);
  assign io_bus.val_psum    = (r_row >= DROP_V);
  assign io_bus.fnh_frm     = r_fnh_frm;
  assign io_bus.busy        = w_busy;
  assign io_bus.done        = w_done;
endmodule

// File: tb/tb_act_loop_ctrl.sv
// tb_act_loop_ctrl: randomized runs of act_loop_ctrl checked against a
// mixed-radix position model of the nested loops.
`timescale 1ns/1ps
module tb_act_loop_ctrl;
  localparam int DROP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  act_loop_ctrl_if ifc ();
  act_loop_ctrl #(.DROP_ROWS(DROP)) dut (.clk(clk), .rst_n(rst_n), .io_bus(ifc));

  typedef struct packed {logic far, lar, lab, fb, vp;} flags_t;

  int total = 0;
  int bad   = 0;

  flags_t obs[$];
  int     fnh_at[$];
  int     n_done, done_gap, req_drop, timed_out, busy_after, busy_at_done, pause_err;
  int     c_len, c_row, c_blk, c_frm, c_pat, c_lay;

  function automatic int n_beats();
    return (c_len+1)*(c_row+1)*(c_blk+1)*(c_frm+1)*(c_pat+1)*(c_lay+1);
  endfunction

  function automatic int beats_per_frm();
    return (c_len+1)*(c_row+1)*(c_blk+1);
  endfunction

  // Position of beat k (0-based) as mixed-radix digits of k
  function automatic flags_t model(int k);
    flags_t f;
    int a, r, b;
    a = k % (c_len+1);
    r = (k / (c_len+1)) % (c_row+1);
    b = (k / ((c_len+1)*(c_row+1))) % (c_blk+1);
    f.far = (a == 0);
    f.lar = (a == c_len);
    f.lab = (a == c_len) && (r == c_row);
    f.fb  = (b == 0);
    f.vp  = (r >= DROP);
    return f;
  endfunction

  function automatic flags_t cur_flags();
    flags_t f;
    f = '{ifc.frt_act_row, ifc.lst_act_row, ifc.lst_act_blk, ifc.frt_blk, ifc.val_psum};
    return f;
  endfunction

  task automatic set_cfg(int l, int r, int b, int f, int p, int y);
    c_len = l; c_row = r; c_blk = b; c_frm = f; c_pat = p; c_lay = y;
    ifc.cfg_len_row = 5'(l); ifc.cfg_num_row = 5'(r); ifc.cfg_num_blk = 6'(b);
    ifc.cfg_num_frm = 5'(f); ifc.cfg_num_pat = 8'(p); ifc.cfg_num_lay = 6'(y);
  endtask

  // Pulse start, then run until done; records per-beat flags and strobes
  task automatic drive_run(int ack_pct, int start_mid, bit scramble, int pause_at, int pause_len);
    int last_beat;
    bit pend, fin, paused;
    flags_t snap;
    obs.delete(); fnh_at.delete();
    n_done = 0; done_gap = -1; req_drop = 0; timed_out = 0;
    busy_after = -1; busy_at_done = -1; pause_err = 0;
    last_beat = -1; pend = 0; fin = 0; paused = 0; snap = '0;
    @(negedge clk); ifc.start = 1'b1; ifc.fetch_ack = 1'b0;
    @(negedge clk); ifc.start = 1'b0;
    if (scramble) begin
      ifc.cfg_len_row = 5'($urandom); ifc.cfg_num_row = 5'($urandom);
      ifc.cfg_num_blk = 6'($urandom); ifc.cfg_num_frm = 5'($urandom);
      ifc.cfg_num_pat = 8'($urandom); ifc.cfg_num_lay = 6'($urandom);
    end
    for (int cyc = 0; cyc < 20000; cyc++) begin
      ifc.fetch_ack = ($urandom_range(99) < ack_pct);
      ifc.start     = (cyc == start_mid);
      paused        = (pause_len > 0) && (cyc >= pause_at) && (cyc < pause_at + pause_len);
`ifdef ACT_LOOP_CTRL_PAUSE_EN
      ifc.pause     = paused;
`endif
      #2;
      if (paused) begin
        if (cyc == pause_at) snap = cur_flags();
        if (ifc.fetch_req) pause_err++;
        if (cur_flags() !== snap) pause_err++;
      end
      if (pause_len > 0 && cyc == pause_at + pause_len && !ifc.fetch_req) pause_err++;
      if (pend && !ifc.fetch_req && !paused) req_drop++;
      if (ifc.fnh_frm) fnh_at.push_back(obs.size());
      if (ifc.done) begin
        n_done++; done_gap = cyc - last_beat; busy_at_done = ifc.busy;
      end
      if (ifc.fetch_req && ifc.fetch_ack) begin
        obs.push_back(cur_flags()); last_beat = cyc;
      end
      pend = ifc.fetch_req && !ifc.fetch_ack;
      if (n_done > 0 && !ifc.done) begin
        busy_after = ifc.busy; fin = 1; break;
      end
      @(negedge clk);
    end
    if (!fin) timed_out = 1;
    ifc.start = 1'b0; ifc.fetch_ack = 1'b0;
`ifdef ACT_LOOP_CTRL_PAUSE_EN
    ifc.pause = 1'b0;
`endif
  endtask

  task automatic test_reset();
    set_cfg(3, 3, 1, 0, 0, 0);
    #13;
    total++; if (ifc.fetch_req !== 1'b0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.fnh_frm !== 1'b0) begin
      bad++; $display("FAIL reset_ctl got req=%b busy=%b done=%b fnh=%b want 0000", ifc.fetch_req, ifc.busy, ifc.done, ifc.fnh_frm);
    end
    total++; if (cur_flags() !== flags_t'({1'b1, 1'b0, 1'b0, 1'b1, 1'(DROP == 0)})) begin
      bad++; $display("FAIL reset_flags got=%b want=%b", cur_flags(), {1'b1, 1'b0, 1'b0, 1'b1, 1'(DROP == 0)});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    total++; if (ifc.fetch_req !== 1'b0 || ifc.busy !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset got req=%b busy=%b want 0 0", ifc.fetch_req, ifc.busy);
    end
  endtask

  task automatic test_smoke();
    set_cfg(0, 0, 0, 0, 0, 0);
    drive_run(100, -1, 0, 0, 0);
    total++; if (timed_out != 0) begin bad++; $display("FAIL smoke_timeout got=%0d want=0", timed_out); end
    total++; if (obs.size() != 1) begin bad++; $display("FAIL smoke_beats got=%0d want=1", obs.size()); end
    total++; if (obs.size() < 1 || obs[0].lab !== 1'b1) begin bad++; $display("FAIL smoke_lst_blk got=%0d beats want lab=1", obs.size()); end
    total++; if (fnh_at.size() != 1 || fnh_at[0] != 1) begin bad++; $display("FAIL smoke_fnh got pulses=%0d want 1 after beat 1", fnh_at.size()); end
    total++; if (n_done != 1 || done_gap != 1) begin bad++; $display("FAIL smoke_done got n=%0d gap=%0d want 1 1", n_done, done_gap); end
    total++; if (busy_at_done != 1 || busy_after != 0) begin bad++; $display("FAIL smoke_busy got at_done=%0d after=%0d want 1 0", busy_at_done, busy_after); end
  endtask

  task automatic test_row_block();
    set_cfg(3, 4, 0, 0, 0, 0);
    drive_run(100, -1, 0, 0, 0);
    total++; if (obs.size() != 20 || timed_out != 0) begin bad++; $display("FAIL rb_beats got=%0d to=%0d want 20 0", obs.size(), timed_out); end
    for (int k = 0; k < obs.size() && k < 20; k++) begin
      total++; if (obs[k] !== model(k)) begin bad++; $display("FAIL rb_flags beat=%0d got=%b want=%b", k+1, obs[k], model(k)); end
    end
    total++; if (n_done != 1 || done_gap != 1) begin bad++; $display("FAIL rb_done got n=%0d gap=%0d want 1 1", n_done, done_gap); end
  endtask

  task automatic test_backpressure();
    set_cfg(1, int'($urandom_range(4)), int'($urandom_range(2)), 0, 1, 0);
    drive_run(30, -1, 0, 0, 0);
    total++; if (obs.size() != n_beats() || timed_out != 0) begin bad++; $display("FAIL bp_beats got=%0d to=%0d want %0d 0", obs.size(), timed_out, n_beats()); end
    for (int k = 0; k < obs.size() && k < n_beats(); k++) begin
      total++; if (obs[k] !== model(k)) begin bad++; $display("FAIL bp_flags beat=%0d got=%b want=%b", k+1, obs[k], model(k)); end
    end
    total++; if (req_drop != 0) begin bad++; $display("FAIL bp_req_drop got=%0d want=0", req_drop); end
    total++; if (n_done != 1 || done_gap != 1) begin bad++; $display("FAIL bp_done got n=%0d gap=%0d want 1 1", n_done, done_gap); end
  endtask

  task automatic test_frame_strobes();
    set_cfg(1, 1, 2, 1, 0, 0);
    drive_run(100, -1, 0, 0, 0);
    total++; if (obs.size() != 24) begin bad++; $display("FAIL fs_beats got=%0d want=24", obs.size()); end
    for (int k = 0; k < obs.size() && k < 24; k++) begin
      total++; if (obs[k].fb !== ((k % 12) < 4)) begin bad++; $display("FAIL fs_frt_blk beat=%0d got=%b want=%b", k+1, obs[k].fb, (k % 12) < 4); end
    end
    total++; if (fnh_at.size() != 2) begin bad++; $display("FAIL fs_fnh_count got=%0d want=2", fnh_at.size()); end
    for (int i = 0; i < fnh_at.size() && i < 2; i++) begin
      total++; if (fnh_at[i] != 12*(i+1)) begin bad++; $display("FAIL fs_fnh_pos got=%0d want=%0d", fnh_at[i], 12*(i+1)); end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      set_cfg(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(2)),
              int'($urandom_range(1)), int'($urandom_range(1)), int'($urandom_range(1)));
      drive_run(int'($urandom_range(100, 25)), -1, 0, 0, 0);
      total++; if (obs.size() != n_beats() || timed_out != 0) begin bad++; $display("FAIL rnd_beats run=%0d got=%0d want=%0d", t, obs.size(), n_beats()); end
      for (int k = 0; k < obs.size() && k < n_beats(); k++) begin
        total++; if (obs[k] !== model(k)) begin bad++; $display("FAIL rnd_flags run=%0d beat=%0d got=%b want=%b", t, k+1, obs[k], model(k)); end
      end
      total++; if (fnh_at.size() != n_beats()/beats_per_frm()) begin bad++; $display("FAIL rnd_fnh_count run=%0d got=%0d want=%0d", t, fnh_at.size(), n_beats()/beats_per_frm()); end
      for (int i = 0; i < fnh_at.size(); i++) begin
        total++; if (fnh_at[i] != beats_per_frm()*(i+1)) begin bad++; $display("FAIL rnd_fnh_pos run=%0d got=%0d want=%0d", t, fnh_at[i], beats_per_frm()*(i+1)); end
      end
      total++; if (req_drop != 0 || n_done != 1 || done_gap != 1) begin bad++; $display("FAIL rnd_hs run=%0d got drop=%0d done=%0d gap=%0d want 0 1 1", t, req_drop, n_done, done_gap); end
    end
  endtask

  task automatic test_start_reset();
    int nb;
    bit hit;
    // start mid-run and cfg changes while busy must not disturb the run
    set_cfg(2, 1, 1, 0, 0, 0);
    drive_run(100, 4, 1, 0, 0);
    total++; if (obs.size() != 12 || n_done != 1) begin bad++; $display("FAIL sr_restart got beats=%0d done=%0d want 12 1", obs.size(), n_done); end
    for (int k = 0; k < obs.size() && k < 12; k++) begin
      total++; if (obs[k] !== model(k)) begin bad++; $display("FAIL sr_flags beat=%0d got=%b want=%b", k+1, obs[k], model(k)); end
    end
    // async reset on beat 7
    set_cfg(2, 1, 1, 0, 0, 0);
    @(negedge clk); ifc.start = 1'b1;
    @(negedge clk); ifc.start = 1'b0; ifc.fetch_ack = 1'b1;
    nb = 0; hit = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      #2;
      if (ifc.fetch_req && ifc.fetch_ack) nb++;
      if (nb == 6) begin hit = 1; break; end
      @(negedge clk);
    end
    total++; if (!hit) begin bad++; $display("FAIL sr_reach_beat7 got beats=%0d want 6", nb); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (ifc.fetch_req !== 1'b0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.fnh_frm !== 1'b0) begin
      bad++; $display("FAIL sr_rst_ctl got req=%b busy=%b done=%b fnh=%b want 0000", ifc.fetch_req, ifc.busy, ifc.done, ifc.fnh_frm);
    end
    total++; if (cur_flags() !== flags_t'({1'b1, 1'b0, 1'b0, 1'b1, 1'(DROP == 0)})) begin
      bad++; $display("FAIL sr_rst_flags got=%b want=%b", cur_flags(), {1'b1, 1'b0, 1'b0, 1'b1, 1'(DROP == 0)});
    end
    nb = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk); #2;
      if (ifc.done || ifc.busy) nb++;
    end
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk); #2;
      if (ifc.done || ifc.busy) nb++;
    end
    total++; if (nb != 0) begin bad++; $display("FAIL sr_no_done got active_cycles=%0d want=0", nb); end
    // re-start completes a full run
    drive_run(70, -1, 0, 0, 0);
    total++; if (obs.size() != 12 || n_done != 1 || timed_out != 0) begin bad++; $display("FAIL sr_rerun got beats=%0d done=%0d want 12 1", obs.size(), n_done); end
    for (int k = 0; k < obs.size() && k < 12; k++) begin
      total++; if (obs[k] !== model(k)) begin bad++; $display("FAIL sr_rerun_flags beat=%0d got=%b want=%b", k+1, obs[k], model(k)); end
    end
  endtask

`ifdef ACT_LOOP_CTRL_PAUSE_EN
  task automatic test_pause();
    set_cfg(3, 2, 0, 0, 0, 0);
    drive_run(100, -1, 0, 2, 5);
    total++; if (pause_err != 0) begin bad++; $display("FAIL pause_hold got errs=%0d want=0", pause_err); end
    total++; if (obs.size() != 12 || n_done != 1) begin bad++; $display("FAIL pause_beats got=%0d done=%0d want 12 1", obs.size(), n_done); end
    for (int k = 0; k < obs.size() && k < 12; k++) begin
      total++; if (obs[k] !== model(k)) begin bad++; $display("FAIL pause_flags beat=%0d got=%b want=%b", k+1, obs[k], model(k)); end
    end
  endtask
`endif

  initial begin
    ifc.start = 1'b0;
    ifc.fetch_ack = 1'b0;
`ifdef ACT_LOOP_CTRL_PAUSE_EN
    ifc.pause = 1'b0;
`endif
    test_reset();
    test_smoke();
    test_row_block();
    test_backpressure();
    test_frame_strobes();
    test_random();
    test_start_reset();
`ifdef ACT_LOOP_CTRL_PAUSE_EN
    test_pause();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/act_loop_ctrl.md
Name: act_loop_ctrl

Overview:
- Parametrised activation-fetch loop controller for the PE array.
- Walks nested loops act -> row -> block -> frame -> patch -> layer.
- Issues one fetch request per activation word over a req/ack handshake.
- Emits row/block/frame position flags, psum-valid and frame-done strobes to the PEC and ping-pong SRAM control.
- Adds an explicit start/busy/done FSM, an independent rows-per-block count, a parametrised psum drop depth, and a layer counter that wraps.

Parameters:
- ROW_W, 5, width of act-in-row and row-in-block counters
- BLK_W, 6, width of block counter
- FRM_W, 5, width of frame counter
- PAT_W, 8, width of patch counter
- LAY_W, 6, width of layer counter
- DROP_ROWS, 2, leading rows of each block whose psums are invalid (0..2^ROW_W-1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a full run; ignored unless IDLE
- cfg_len_row  in  ROW_W  acts per row minus 1
- cfg_num_row  in  ROW_W  rows per block minus 1
- cfg_num_blk  in  BLK_W  blocks per frame minus 1
- cfg_num_frm  in  FRM_W  frames per patch minus 1
- cfg_num_pat  in  PAT_W  patches per layer minus 1
- cfg_num_lay  in  LAY_W  layers per run minus 1
- fetch_req  out  1  request one activation word
- fetch_ack  in  1  word accepted; beat = fetch_req && fetch_ack
- frt_act_row  out  1  current beat is first act of row
- lst_act_row  out  1  current beat is last act of row
- lst_act_blk  out  1  current beat is last act of block
- frt_blk  out  1  block counter == 0
- val_psum  out  1  row counter >= DROP_ROWS
- fnh_frm  out  1  one-cycle pulse, frame boundary crossed
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle pulse, run complete

Behaviour:
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE on the beat with all counters at their cfg maxima.
  - DONE -> IDLE after one cycle, with done=1 in that cycle.
- Reset values: all counters 0, FSM IDLE; fetch_req, fnh_frm, done, busy = 0. Combinational flags follow from zero counters: frt_act_row=1, frt_blk=1, val_psum=(DROP_ROWS==0), lst_* per cfg compare gated by RUN.
- fetch_req = 1 only in RUN. Once asserted it stays high until the beat. Counters change only on a beat; no beat means all counters hold.
- cfg_* are sampled into internal registers on start and held for the whole run. Changes while busy have no effect.
- Counter cascade, all on a beat:
  - act wraps at cfg_len_row; row increments on act wrap.
  - row wraps at cfg_num_row; blk increments on row wrap.
  - blk wraps at cfg_num_blk; then frm, then pat, then lay, in the same pattern.
  - Every level wraps to 0, including lay.
- lst_act_row = RUN && act==len_row.
- lst_act_blk = lst_act_row && row==num_row.
- frt_act_row = act==0.
- frt_blk = blk==0.
- val_psum = row>=DROP_ROWS, unsigned compare.
- fnh_frm is registered and asserts the cycle after the beat that wraps blk. Zero latency to the next beat is not required. Exactly one pulse per frame, including the final frame.
- done asserts the cycle after the final beat (DONE state); busy=1 through DONE.
- Any cfg value 0 means a single iteration at that level. All-zero cfg gives 1 beat, then done.
- start while busy: ignored, no restart.
- Async reset mid-run: immediate return to IDLE, counters cleared, no done pulse.

Optional Feature:
- Macro ACT_LOOP_CTRL_PAUSE_EN.
- When defined: extra input port pause (1 bit). In RUN with pause=1, fetch_req is forced 0 and counters hold. A beat is impossible while paused. fetch_req reasserts the cycle pause falls, with no state lost.
- When undefined: no pause port; fetch_req depends only on FSM state.

Test Plan:
- Smoke: cfg all 0, start, ack tied 1 -> exactly 1 beat; lst_act_blk=1 on it; fnh_frm pulse next cycle; done pulse the cycle after the beat; busy falls after done.
- Row/block: len_row=3, num_row=4, others 0, DROP_ROWS=2, ack=1 -> 20 beats; lst_act_row on beats 4,8,...,20; val_psum 0 for beats 1-8 and 1 for 9-20; one done.
- Backpressure: len_row=1, ack random 30% -> counters advance only on beats; fetch_req never drops before its ack; beat count 2 per row still exact.
- Frame strobes: num_blk=2, num_frm=1, len_row=num_row=1 -> 24 beats; fnh_frm exactly 2 pulses; frt_blk high for beats 1-4 and 13-16.
- Start/reset robustness: start pulsed mid-run -> no effect on counts. rst_n low at beat 7 -> outputs at reset values, no done. Re-start -> full run completes.
- Pause (macro on): pause high 5 cycles mid-row -> fetch_req 0 during pause, counters frozen, total beats unchanged.
